line_buf_window: RTL
====================

Name: line_buf_window

Overview:
Parametrised successor to buf_to_gauss. Converts a raster pixel stream into a K×K sliding window, with K = 2*R_KERNEL+1, for the Gaussian, Sobel and NMS stages. Adds valid gaps, frame-start resync, an end-of-frame flag and generic pixel width and radius. Window outputs are valid-only (cropped), giving (WIDTH-2R)*(HEIGHT-2R) windows per frame.

Parameters:
- WIDTH, 512: pixels per line.
- HEIGHT, 512: lines per frame.
- R_KERNEL, 2: kernel radius. K = 2*R_KERNEL+1; legal range 1..3.
- PIX_W, 8: bits per pixel.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pix is accepted this cycle.
- in_sof  in  1  qualifies in_valid; the accepted pixel is row 0, col 0.
- in_pix  in  PIX_W  raster-order input pixel.
- win_pix  out  K*K*PIX_W  flattened window. Slice i = r*K+c occupies bits [i*PIX_W +: PIX_W]; r=0 is the top (oldest) row, c=0 is the left column.
- out_valid  out  1  win_pix holds a complete window; one-cycle pulse per window.
- out_eof  out  1  high together with out_valid on the last window of the frame.

Behaviour:
- Reset (async on rst_n low):
  - row, col, FSM return to their initial values (row=0, col=0, FILL).
  - win_pix=0, out_valid=0, out_eof=0.
  - Line-buffer RAM contents are don't-care.
- Counters:
  - col counts 0..WIDTH-1 and row counts 0..HEIGHT-1; both advance only on accepted pixels.
  - After (row=HEIGHT-1, col=WIDTH-1) both wrap to 0.
  - in_sof forces the accepted pixel to be (0,0); the counters then continue from (0,1).
- Storage:
  - 2*R_KERNEL line buffers of WIDTH×PIX_W, read and written at address col.
  - Line n feeds line n+1.
  - Window register array shifts left by one column per accepted pixel.
  - The new right column is {line buffers oldest→newest, in_pix}.
- No accepted pixel: window, counters and line buffers hold; out_valid=0.
- FSM:
  - FILL: row < 2R; out_valid is never asserted.
  - FILL→STREAM when a pixel is accepted at row=2R, col=0.
  - STREAM: a window is emitted on an accepted pixel with col ≥ 2R.
  - STREAM→FILL on frame wrap, or on in_sof in any state.
- Output timing:
  - out_valid is registered: it asserts the cycle after the accepting edge.
  - The emitted window is centred at (row-R, col-R).
  - Latency from in_pix at (r, c) to the window containing it as bottom-right: 1 clock.
- out_eof: asserted with the window accepted at (HEIGHT-1, WIDTH-1).
- Line wrap: the columns at col < 2R mix the previous line's tail. They are never emitted, so no edge replication is needed.
- Simultaneous in_sof at (HEIGHT-1, WIDTH-1): in_sof wins. No out_eof; the pixel becomes (0,0).
- Reset mid-frame: the next accepted pixel is (0,0), regardless of in_sof.
- Throughput: one pixel per clock, no backpressure. The downstream must accept every out_valid.

Optional Feature:
LINE_BUF_WINDOW_COORD_EN
- Defined: adds ports out_col and out_row, width $clog2(WIDTH) and $clog2(HEIGHT). They carry the window centre coordinate, registered alongside out_valid, and reset to 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package edge_pkg holds:
  - function clog2_f;
  - localparams K and WIN_N = K*K;
  - FSM state typedef {FILL, STREAM}.
- One sub-module, line_fifo: single-line delay RAM of depth WIDTH, PIX_W wide, with write enable and address. It is instantiated 2*R_KERNEL times via generate.

Test Plan:
- Basic stream, WIDTH=HEIGHT=8, R=1, pixel = col+16*row, continuous valid:
  - exactly 36 out_valid pulses;
  - first window slices 0..8 = {0,1,2,16,17,18,32,33,34};
  - last window centre 0x66;
  - out_eof only on pulse 36.
- Defaults 512×512, R=2, reference-style pattern row_gen wrapping at 255:
  - 258064 windows per frame;
  - window slice 12 equals the centre pixel;
  - two back-to-back frames give two out_eof pulses.
- Random in_valid gaps (~50% duty) on the 8×8 stream: window sequence identical to the continuous case; no out_valid during gap cycles.
- in_sof asserted at (row 4, col 3), then a fresh 8×8 frame: no output until the new row 2, col 2; then 36 correct windows.
- rst_n pulsed low mid-STREAM: out_valid=0 and win_pix=0 immediately (async); the next full frame yields 36 correct windows.
- With LINE_BUF_WINDOW_COORD_EN: first window (out_col, out_row)=(1,1); last window (6,6).

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-detection front end.
// K and WIN_N are the window size and tap count at the default radius.
// Instances with another R_KERNEL compute their own size from that parameter.
package edge_pkg;

  // Address width needed for v entries. Never returns less than 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int R_DEF = 2;
  localparam int K     = 2 * R_DEF + 1;
  localparam int WIN_N = K * K;

  typedef enum logic {FILL, STREAM} state_t;

endpackage

// File: rtl/line_fifo.sv
// Single-line delay RAM with DEPTH entries of PIX_W bits.
// It is read and written at the same address. The read is asynchronous and
// returns the value from one line earlier, before this cycle's write lands.
module line_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int PIX_W = 8,
  parameter int AW    = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write port. The contents carry no reset.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buf_window.sv
// Raster stream to KxK sliding window, with K = 2*R_KERNEL+1.
// A chain of 2*R_KERNEL line delays feeds the right column of a window
// register. Only fully valid windows are emitted, so no edge replication
// is needed.
// Optional: define LINE_BUF_WINDOW_COORD_EN to add out_col/out_row, which
// carry the centre coordinate of each emitted window.
module line_buf_window
  import edge_pkg::*;
#(
  parameter int WIDTH    = 512,
  parameter int HEIGHT   = 512,
  parameter int R_KERNEL = 2,
  parameter int PIX_W    = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  in_valid,
  input  logic                                                  in_sof,
  input  logic [PIX_W-1:0]                                      in_pix,
  output logic [(2*R_KERNEL+1)*(2*R_KERNEL+1)*PIX_W-1:0]        win_pix,
  output logic                                                  out_valid,
  output logic                                                  out_eof
`ifdef LINE_BUF_WINDOW_COORD_EN
  ,
  output logic [clog2_f(WIDTH)-1:0]                             out_col,
  output logic [clog2_f(HEIGHT)-1:0]                            out_row
`endif
);

  localparam int KW  = 2 * R_KERNEL + 1;
  localparam int NLB = 2 * R_KERNEL;
  localparam int CW  = clog2_f(WIDTH);
  localparam int RW  = clog2_f(HEIGHT);

  state_t          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, pcol;
  logic [RW-1:0]   row, row_nxt, prow;
  logic            at_last, emit;

  logic [NLB-1:0][PIX_W-1:0]         lb_rd, lb_wr;
  logic [KW-1:0][PIX_W-1:0]          ncol;
  logic [KW-1:0][KW-1:0][PIX_W-1:0]  win;

  // Next position, FSM and emit decision. in_sof overrides the position with (0,0).
  always_comb begin
    pcol      = in_sof ? '0 : col;
    prow      = in_sof ? '0 : row;
    at_last   = (prow == RW'(HEIGHT-1)) && (pcol == CW'(WIDTH-1));
    col_nxt   = col;
    row_nxt   = row;
    state_nxt = state;
    emit      = 1'b0;
    if (in_valid) begin
      if (pcol == CW'(WIDTH-1)) begin
        col_nxt = '0;
        row_nxt = (prow == RW'(HEIGHT-1)) ? '0 : prow + 1'b1;
      end else begin
        col_nxt = pcol + 1'b1;
        row_nxt = prow;
      end
      if (in_sof) state_nxt = FILL;
      else begin
        case (state)
          FILL:    if (row == RW'(NLB) && col == '0) state_nxt = STREAM;
          STREAM:  if (at_last) state_nxt = FILL;
          default: state_nxt = FILL;
        endcase
      end
      emit = !in_sof && (state == STREAM) && (col >= CW'(NLB));
    end
  end

  // Position counters and FSM state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end

  // The chain runs in_pix -> lb[0] -> ... -> lb[NLB-1]. The last stage holds the oldest line.
  always_comb begin
    lb_wr[0] = in_pix;
    for (int g = 1; g < NLB; g++) lb_wr[g] = lb_rd[g-1];
    ncol[KW-1] = in_pix;
    for (int r = 0; r < NLB; r++) ncol[r] = lb_rd[NLB-1-r];
  end

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    line_fifo #(.DEPTH(WIDTH), .PIX_W(PIX_W), .AW(CW)) u_lb (
      .clk   (clk),
      .we    (in_valid),
      .addr  (pcol),
      .wdata (lb_wr[g]),
      .rdata (lb_rd[g])
    );
  end

  // Window shifts left one column per accepted pixel. The new column enters on the right.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) win <= '0;
    else if (in_valid)
      for (int r = 0; r < KW; r++) begin
        for (int c = 0; c < KW-1; c++) win[r][c] <= win[r][c+1];
        win[r][KW-1] <= ncol[r];
      end

  assign win_pix = win;

  // Registered flags. They line up with the window update on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= emit;
      out_eof   <= emit && at_last;
    end

`ifdef LINE_BUF_WINDOW_COORD_EN
  // Window centre sits R_KERNEL behind the accepted pixel in both axes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_col <= '0;
      out_row <= '0;
    end else if (emit) begin
      out_col <= col - CW'(R_KERNEL);
      out_row <= row - RW'(R_KERNEL);
    end
`endif

endmodule
